// File: rtl/bp_be_pkg.sv
// Shared back-end definitions for the dual FE queue: pointer layout and the
// minimum number of free slots the queue must have before it accepts entries.
package bp_be_pkg;

    localparam int fe_queue_min_free_gp  = 2;
    localparam int fe_queue_els_gp       = 16;
    localparam int fe_queue_idx_width_gp = $clog2(fe_queue_els_gp);

    typedef struct packed {
        logic                             wrap;
        logic [fe_queue_idx_width_gp-1:0] idx;
    } bp_be_fe_queue_ptr_s;

endpackage

// File: rtl/bp_be_dual_fe_queue_mem.sv
// Storage for the dual FE queue: els_p entries, two write ports, two read ports.
// Write port 2 only fires when the second entry is valid.
module bp_be_dual_fe_queue_mem
    import bp_be_pkg::*;
#(
    parameter  int els_p         = fe_queue_els_gp,
    parameter  int entry_width_p = 128,
    localparam int idx_width_lp  = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w1_v_i,
    input  logic [idx_width_lp-1:0]  w1_idx_i,
    input  logic [entry_width_p-1:0] w1_data_i,
    input  logic                     w2_v_i,
    input  logic [idx_width_lp-1:0]  w2_idx_i,
    input  logic [entry_width_p-1:0] w2_data_i,
    input  logic [idx_width_lp-1:0]  r1_idx_i,
    input  logic [idx_width_lp-1:0]  r2_idx_i,
    output logic [entry_width_p-1:0] r1_data_o,
    output logic [entry_width_p-1:0] r2_data_o
);

    logic [entry_width_p-1:0] mem_q [els_p];

    // Contents are deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (w1_v_i) mem_q[w1_idx_i] <= w1_data_i;
        if (w2_v_i) mem_q[w2_idx_i] <= w2_data_i;
    end

    assign r1_data_o = mem_q[r1_idx_i];
    assign r2_data_o = mem_q[r2_idx_i];

endmodule

// File: rtl/bp_be_dual_fe_queue.sv
// Speculative dual-ported FE queue with write/read/commit pointers over one ring.
// Optional perf counters are built only with BP_BE_DUAL_FE_QUEUE_PERF_EN defined.
module bp_be_dual_fe_queue
    import bp_be_pkg::*;
#(
    parameter  int els_p         = fe_queue_els_gp,
    parameter  int entry_width_p = 128,
    localparam int ptr_width_lp  = $clog2(els_p) + 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [entry_width_p-1:0] fe_queue1_i,
    input  logic [entry_width_p-1:0] fe_queue2_i,
    input  logic                     fe_queue_v1_i,
    input  logic                     fe_queue_v2_i,
    output logic                     fe_queue_ready_o,
    output logic [entry_width_p-1:0] fe_queue1_o,
    output logic [entry_width_p-1:0] fe_queue2_o,
    output logic                     fe_queue_v1_o,
    output logic                     fe_queue_v2_o,
    input  logic [1:0]               yumi_cnt_i,
    input  logic                     deq_v_i,
    input  logic                     roll_v_i,
    input  logic                     clr_v_i,
    output logic [31:0]              stall_cnt_o,
    output logic [ptr_width_lp-1:0]  hwm_o
);

    localparam int idx_width_lp = ptr_width_lp - 1;
    localparam logic [ptr_width_lp-1:0] max_occ_lp = ptr_width_lp'(els_p - fe_queue_min_free_gp);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cptr_q, cptr_d;
    logic [ptr_width_lp-1:0] occ, unissued;
    logic                    ready, enq_v, enq2_v;

    assign occ      = wptr_q - cptr_q;
    assign unissued = wptr_q - rptr_q;
    // A single-slot hole is never offered, so ready means room for a full pair.
    assign ready    = (occ <= max_occ_lp);
    assign enq_v    = fe_queue_v1_i & ready & ~clr_v_i;
    assign enq2_v   = enq_v & fe_queue_v2_i;

    always_comb begin
        cptr_d = cptr_q + ptr_width_lp'(deq_v_i);
        wptr_d = wptr_q + ptr_width_lp'(enq_v) + ptr_width_lp'(enq2_v);
        rptr_d = rptr_q + ptr_width_lp'(yumi_cnt_i);
        if (clr_v_i) begin
            wptr_d = cptr_d;
            rptr_d = cptr_d;
        end else if (roll_v_i) begin
            rptr_d = cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    bp_be_dual_fe_queue_mem #(
        .els_p        (els_p),
        .entry_width_p(entry_width_p)
    ) mem (
        .clk_i    (clk_i),
        .w1_v_i   (enq_v),
        .w1_idx_i (wptr_q[idx_width_lp-1:0]),
        .w1_data_i(fe_queue1_i),
        .w2_v_i   (enq2_v),
        .w2_idx_i (wptr_q[idx_width_lp-1:0] + idx_width_lp'(1)),
        .w2_data_i(fe_queue2_i),
        .r1_idx_i (rptr_q[idx_width_lp-1:0]),
        .r2_idx_i (rptr_q[idx_width_lp-1:0] + idx_width_lp'(1)),
        .r1_data_o(fe_queue1_o),
        .r2_data_o(fe_queue2_o)
    );

    assign fe_queue_ready_o = reset_i | ready;
    assign fe_queue_v1_o    = ~reset_i & (unissued != '0);
    assign fe_queue_v2_o    = ~reset_i & (unissued > ptr_width_lp'(1));

`ifdef BP_BE_DUAL_FE_QUEUE_PERF_EN
    logic [31:0]             stall_q;
    logic [ptr_width_lp-1:0] hwm_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= '0;
            hwm_q   <= '0;
        end else begin
            if (fe_queue_v1_i & ~ready & ~(&stall_q)) stall_q <= stall_q + 32'd1;
            if (occ > hwm_q) hwm_q <= occ;
        end
    end

    assign stall_cnt_o = reset_i ? '0 : stall_q;
    assign hwm_o       = reset_i ? '0 : hwm_q;
`else
    assign stall_cnt_o = '0;
    assign hwm_o       = '0;
`endif

    a_v2_needs_v1: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_queue_v2_i |-> fe_queue_v1_i);
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_cnt_i <= (2'(fe_queue_v1_o) + 2'(fe_queue_v2_o)));
    a_deq_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        deq_v_i |-> (cptr_q != rptr_q));

endmodule

// File: tb/tb_bp_be_dual_fe_queue.sv
// Self-checking bench for bp_be_dual_fe_queue against a queue-based reference model.
module tb_bp_be_dual_fe_queue;
    localparam int ELS = 16;
    localparam int W   = 128;
    localparam int PW  = 5;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  fe_queue1_i = '0, fe_queue2_i = '0;
    logic          fe_queue_v1_i = 1'b0, fe_queue_v2_i = 1'b0;
    logic          fe_queue_ready_o;
    logic [W-1:0]  fe_queue1_o, fe_queue2_o;
    logic          fe_queue_v1_o, fe_queue_v2_o;
    logic [1:0]    yumi_cnt_i = '0;
    logic          deq_v_i = 1'b0, roll_v_i = 1'b0, clr_v_i = 1'b0;
    logic [31:0]   stall_cnt_o;
    logic [PW-1:0] hwm_o;

    int tests_run = 0;
    int failures  = 0;

    // Reference model: uncommitted entries oldest-first; the first 'issued' are issued.
    logic [W-1:0] mq[$];
    logic [W-1:0] hist[$];
    int issued = 0;
    int m_stall = 0;
    int m_hwm = 0;

    always #5 clk = ~clk;

    bp_be_dual_fe_queue #(.els_p(ELS), .entry_width_p(W)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .fe_queue1_i(fe_queue1_i), .fe_queue2_i(fe_queue2_i),
        .fe_queue_v1_i(fe_queue_v1_i), .fe_queue_v2_i(fe_queue_v2_i),
        .fe_queue_ready_o(fe_queue_ready_o),
        .fe_queue1_o(fe_queue1_o), .fe_queue2_o(fe_queue2_o),
        .fe_queue_v1_o(fe_queue_v1_o), .fe_queue_v2_o(fe_queue_v2_o),
        .yumi_cnt_i(yumi_cnt_i), .deq_v_i(deq_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i),
        .stall_cnt_o(stall_cnt_o), .hwm_o(hwm_o)
    );

    function automatic logic [W-1:0] rand_entry();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int m_unissued();
        return mq.size() - issued;
    endfunction

    task automatic idle();
        fe_queue_v1_i = 1'b0; fe_queue_v2_i = 1'b0; yumi_cnt_i = '0;
        deq_v_i = 1'b0; roll_v_i = 1'b0; clr_v_i = 1'b0;
    endtask

    task automatic step(input bit v1, input bit v2, input int yumi,
                        input bit deq, input bit roll, input bit clr);
        logic [W-1:0] d1, d2;
        bit rdy, acc;
        d1 = rand_entry(); d2 = rand_entry();
        fe_queue1_i = d1; fe_queue2_i = d2;
        fe_queue_v1_i = v1; fe_queue_v2_i = v2; yumi_cnt_i = 2'(yumi);
        deq_v_i = deq; roll_v_i = roll; clr_v_i = clr;
        rdy = (ELS - mq.size()) >= 2;
        acc = v1 && rdy && !clr;
        @(posedge clk);
        if (v1 && !rdy) m_stall++;
        if (mq.size() > m_hwm) m_hwm = mq.size();
        if (deq) begin void'(mq.pop_front()); issued--; end
        if (clr) begin
            mq.delete(); issued = 0;
        end else begin
            if (roll) issued = 0; else issued += yumi;
            if (acc) begin
                mq.push_back(d1); hist.push_back(d1);
                if (v2) begin mq.push_back(d2); hist.push_back(d2); end
            end
        end
        #1;
        idle();
    endtask

    task automatic do_reset(input int n);
        idle();
        reset_i = 1'b1;
        repeat (n) @(posedge clk);
        mq.delete(); hist.delete(); issued = 0; m_stall = 0; m_hwm = 0;
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        tests_run++; if (fe_queue_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b exp 1", fe_queue_ready_o); end
        tests_run++; if ({fe_queue_v1_o, fe_queue_v2_o} !== 2'b00) begin failures++; $display("FAIL reset_valid: got %0b%0b exp 00", fe_queue_v1_o, fe_queue_v2_o); end
        tests_run++; if (stall_cnt_o !== 32'd0 || hwm_o !== '0) begin failures++; $display("FAIL reset_perf: got stall %0d hwm %0d exp 0 0", stall_cnt_o, hwm_o); end
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        reset_i = 1'b1;
        #1;
        tests_run++; if (fe_queue_ready_o !== 1'b1 || fe_queue_v1_o !== 1'b0 || fe_queue_v2_o !== 1'b0) begin
            failures++; $display("FAIL during_reset: got rdy %0b v1 %0b v2 %0b exp 1 0 0", fe_queue_ready_o, fe_queue_v1_o, fe_queue_v2_o); end
        @(posedge clk);
        mq.delete(); hist.delete(); issued = 0; m_stall = 0; m_hwm = 0;
        #1;
        reset_i = 1'b0;
        tests_run++; if (fe_queue_v1_o !== 1'b0 || hwm_o !== '0) begin failures++; $display("FAIL midop_reset: got v1 %0b hwm %0d exp 0 0", fe_queue_v1_o, hwm_o); end
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (fe_queue_v1_o !== 1'b1 || fe_queue_v2_o !== 1'b0 || fe_queue1_o !== hist[0]) begin
            failures++; $display("FAIL post_reset_enq: got v1 %0b v2 %0b d1 %0h exp 1 0 %0h", fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, hist[0]); end
    endtask

    task automatic test_fill();
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0, 0, 0);
            tests_run++; if (fe_queue_ready_o !== (i < 7)) begin failures++; $display("FAIL fill_ready[%0d]: got %0b exp %0b", i, fe_queue_ready_o, (i < 7)); end
        end
        tests_run++; if (fe_queue_v1_o !== 1'b1 || fe_queue_v2_o !== 1'b1) begin failures++; $display("FAIL fill_valid: got %0b%0b exp 11", fe_queue_v1_o, fe_queue_v2_o); end
        tests_run++; if (fe_queue1_o !== hist[0] || fe_queue2_o !== hist[1]) begin
            failures++; $display("FAIL fill_data: got %0h %0h exp %0h %0h", fe_queue1_o, fe_queue2_o, hist[0], hist[1]); end
    endtask

    task automatic test_roll();
        do_reset(1);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 2, 0, 0, 0);
        step(0, 0, 2, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        tests_run++; if (fe_queue1_o !== hist[4] || fe_queue2_o !== hist[5]) begin
            failures++; $display("FAIL pre_roll_data: got %0h %0h exp %0h %0h", fe_queue1_o, fe_queue2_o, hist[4], hist[5]); end
        step(0, 0, 0, 0, 1, 0);
        tests_run++; if (fe_queue1_o !== hist[1] || fe_queue2_o !== hist[2]) begin
            failures++; $display("FAIL roll_data: got %0h %0h exp %0h %0h", fe_queue1_o, fe_queue2_o, hist[1], hist[2]); end
        tests_run++; if (m_unissued() !== 5 || fe_queue_v2_o !== 1'b1) begin failures++; $display("FAIL roll_unissued: got model %0d v2 %0b exp 5 1", m_unissued(), fe_queue_v2_o); end
    endtask

    task automatic test_clear();
        logic [W-1:0] e;
        do_reset(1);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 2, 0, 0, 0);
        step(0, 0, 2, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 1, 1, 1);
        tests_run++; if (fe_queue_v1_o !== 1'b0 || fe_queue_v2_o !== 1'b0 || fe_queue_ready_o !== 1'b1) begin
            failures++; $display("FAIL clear_state: got v1 %0b v2 %0b rdy %0b exp 0 0 1", fe_queue_v1_o, fe_queue_v2_o, fe_queue_ready_o); end
        step(1, 0, 0, 0, 0, 0);
        e = hist[hist.size()-1];
        tests_run++; if (fe_queue_v1_o !== 1'b1 || fe_queue_v2_o !== 1'b0 || fe_queue1_o !== e) begin
            failures++; $display("FAIL clear_then_enq: got v1 %0b v2 %0b d1 %0h exp 1 0 %0h", fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, e); end
    endtask

    task automatic test_wrap();
        int recv = 0;
        int cyc = 0;
        int y;
        do_reset(1);
        while ((recv < 40) && (cyc < 200)) begin
            y = (m_unissued() > 2) ? 2 : m_unissued();
            if (y >= 1) begin
                tests_run++; if (fe_queue1_o !== hist[recv]) begin failures++; $display("FAIL wrap_d1[%0d]: got %0h exp %0h", recv, fe_queue1_o, hist[recv]); end
            end
            if (y == 2) begin
                tests_run++; if (fe_queue2_o !== hist[recv+1]) begin failures++; $display("FAIL wrap_d2[%0d]: got %0h exp %0h", recv+1, fe_queue2_o, hist[recv+1]); end
            end
            if (mq.size() <= 14) begin
                tests_run++; if (fe_queue_ready_o !== 1'b1) begin failures++; $display("FAIL wrap_ready: got 0 exp 1 at occ %0d", mq.size()); end
            end
            recv += y;
            step(hist.size() < 40, hist.size() < 39, y, issued > 0, 0, 0);
            cyc++;
        end
        tests_run++; if (recv < 40) begin failures++; $display("FAIL wrap_timeout: got %0d entries exp 40", recv); end
    endtask

    task automatic test_full_boundary();
        int drained = 0;
        int y;
        do_reset(1);
        repeat (7) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (fe_queue_ready_o !== 1'b0) begin failures++; $display("FAIL occ15_ready: got %0b exp 0", fe_queue_ready_o); end
        step(1, 0, 0, 0, 0, 0);
        tests_run++; if (fe_queue_ready_o !== 1'b0) begin failures++; $display("FAIL occ15_hold: got %0b exp 0", fe_queue_ready_o); end
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        tests_run++; if (fe_queue_ready_o !== 1'b1) begin failures++; $display("FAIL occ14_ready: got %0b exp 1", fe_queue_ready_o); end
        for (int c = 0; c < 20 && m_unissued() > 0; c++) begin
            y = (m_unissued() > 2) ? 2 : m_unissued();
            tests_run++; if (fe_queue1_o !== hist[1+drained]) begin failures++; $display("FAIL occ15_drain[%0d]: got %0h exp %0h", drained, fe_queue1_o, hist[1+drained]); end
            drained += y;
            step(0, 0, y, 0, 0, 0);
        end
        tests_run++; if (drained !== 14 || fe_queue_v1_o !== 1'b0) begin failures++; $display("FAIL occ15_count: got %0d v1 %0b exp 14 0", drained, fe_queue_v1_o); end
    endtask

    task automatic test_perf();
        do_reset(1);
        repeat (8) step(1, 1, 0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0);
`ifdef BP_BE_DUAL_FE_QUEUE_PERF_EN
        tests_run++; if (stall_cnt_o !== 32'd5) begin failures++; $display("FAIL perf_stall: got %0d exp 5", stall_cnt_o); end
        tests_run++; if (hwm_o !== PW'(16)) begin failures++; $display("FAIL perf_hwm: got %0d exp 16", hwm_o); end
`else
        tests_run++; if (stall_cnt_o !== 32'd0) begin failures++; $display("FAIL perf_stall_off: got %0d exp 0", stall_cnt_o); end
        tests_run++; if (hwm_o !== '0) begin failures++; $display("FAIL perf_hwm_off: got %0d exp 0", hwm_o); end
`endif
    endtask

    task automatic test_random();
        bit v1, v2, deq, roll, clr;
        int u, y;
        do_reset(1);
        for (int c = 0; c < 400; c++) begin
            u = m_unissued();
            tests_run++; if (fe_queue_ready_o !== ((ELS - mq.size()) >= 2) || fe_queue_v1_o !== (u >= 1) || fe_queue_v2_o !== (u >= 2)) begin
                failures++; $display("FAIL rand_ctl[%0d]: got rdy %0b v1 %0b v2 %0b occ %0d unissued %0d", c, fe_queue_ready_o, fe_queue_v1_o, fe_queue_v2_o, mq.size(), u); end
            if (u >= 1) begin
                tests_run++; if (fe_queue1_o !== mq[issued]) begin failures++; $display("FAIL rand_d1[%0d]: got %0h exp %0h", c, fe_queue1_o, mq[issued]); end
            end
            if (u >= 2) begin
                tests_run++; if (fe_queue2_o !== mq[issued+1]) begin failures++; $display("FAIL rand_d2[%0d]: got %0h exp %0h", c, fe_queue2_o, mq[issued+1]); end
            end
            v1   = $urandom_range(0, 3) != 0;
            v2   = v1 && ($urandom_range(0, 1) == 1);
            y    = $urandom_range(0, (u > 2) ? 2 : u);
            deq  = (issued > 0) && ($urandom_range(0, 1) == 1);
            roll = $urandom_range(0, 15) == 0;
            clr  = $urandom_range(0, 31) == 0;
            step(v1, v2, y, deq, roll, clr);
        end
`ifdef BP_BE_DUAL_FE_QUEUE_PERF_EN
        tests_run++; if (stall_cnt_o !== 32'(m_stall) || hwm_o !== PW'(m_hwm)) begin
            failures++; $display("FAIL rand_perf: got stall %0d hwm %0d exp %0d %0d", stall_cnt_o, hwm_o, m_stall, m_hwm); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_roll();
        test_clear();
        test_wrap();
        test_full_boundary();
        test_perf();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bp_be_dual_fe_queue.md
Name: bp_be_dual_fe_queue

Overview:
- Dual-ported speculative FIFO between the dual-fetch front end and the dual-issue scheduler.
- Accepts up to two FE queue entries per cycle and presents the two oldest unissued entries to the scheduler.
- Retains issued entries until commit, so a rollback can replay them and a clear can discard all uncommitted work.
- Three pointers (write, read, commit) over one circular buffer.

Parameters:
- els_p, 16, number of entries; power of two, at least 4.
- entry_width_p, 128, width of one FE queue entry (bp_fe_queue_s width).
- ptr_width_lp, $clog2(els_p)+1, derived; pointer width including wrap bit.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- fe_queue1_i  in  entry_width_p  older incoming entry
- fe_queue2_i  in  entry_width_p  younger incoming entry
- fe_queue_v1_i  in  1  entry 1 valid
- fe_queue_v2_i  in  1  entry 2 valid; legal only with v1
- fe_queue_ready_o  out  1  at least two free slots
- fe_queue1_o  out  entry_width_p  oldest unissued entry
- fe_queue2_o  out  entry_width_p  second-oldest unissued entry
- fe_queue_v1_o  out  1  fe_queue1_o valid
- fe_queue_v2_o  out  1  fe_queue2_o valid
- yumi_cnt_i  in  2  entries issued this cycle: 0, 1 or 2
- deq_v_i  in  1  commit one entry (advance commit pointer)
- roll_v_i  in  1  replay: read pointer returns to commit pointer
- clr_v_i  in  1  discard all uncommitted entries
- stall_cnt_o  out  32  perf: cycles FE valid while not ready
- hwm_o  out  ptr_width_lp  perf: occupancy high-water mark

Behaviour:
- Reset: wptr, rptr and cptr all 0. Outputs during reset: fe_queue_ready_o=1, v1_o=0, v2_o=0, perf counters 0. Memory contents are not reset.
- Occupancy and space:
  - occ = wptr - cptr, modulo 2^ptr_width_lp.
  - unissued = wptr - rptr.
  - ready_o = (els_p - occ) >= 2. Combinational from registered pointers only; no input dependency.
- Enqueue:
  - Accepted when v1 & ready_o and clr_v_i=0.
  - Entry 1 is written at wptr; if v2 is set, entry 2 is written at wptr+1.
  - wptr advances by v1+v2.
  - v2 without v1 is an error (assertion); it is ignored.
  - No bypass: a written entry becomes visible on the outputs the next cycle.
- Read side:
  - v1_o = unissued >= 1; v2_o = unissued >= 2.
  - data1 = mem[rptr]; data2 = mem[rptr+1] (index wraps).
- Issue:
  - rptr advances by yumi_cnt_i.
  - Requires yumi_cnt_i <= v1_o+v2_o; a violation is an assertion failure.
  - Ignored in a cycle with roll_v_i or clr_v_i.
- Commit:
  - cptr advances by 1 on deq_v_i.
  - Requires cptr != rptr; a violation is an assertion failure.
- Priority per cycle: compute cptr_n first, then:
  - clr_v_i: rptr_n = wptr_n = cptr_n; enqueue dropped. clr dominates roll.
  - roll_v_i (no clr): rptr_n = cptr_n; enqueue still accepted; wptr is unchanged apart from the enqueue.
  - Otherwise: normal updates.
- Wrap-around: the wrap bit distinguishes full from empty. occ = els_p is full (ready_o=0), even though wptr and cptr have equal index bits.
- Full boundary: occ = els_p-1 gives ready_o=0, because a single-entry hole is never offered.
- Reset mid-operation: all pointers return to 0 on the next edge; pending entries are lost.

Optional Feature:
- Macro: BP_BE_DUAL_FE_QUEUE_PERF_EN.
- Defined:
  - stall_cnt_o increments (saturating at 2^32-1) each cycle fe_queue_v1_i & ~fe_queue_ready_o.
  - hwm_o registers max(hwm_o, occ) every cycle.
  - Both are cleared by reset only.
- Undefined: both ports tie to 0 and no perf flops are built.

Decomposition:
- Shared package bp_be_pkg: bp_be_fe_queue_ptr_s (wrap bit + index) and the localparam for minimum free slots (2).
- Sub-module bp_be_dual_fe_queue_mem: els_p-entry, 2-write/2-read register array; write port 2 is gated by v2.
- Pointer arithmetic and priority logic stay in the top module.

Test Plan:
- Reset, then v1=v2=1 for 8 cycles with yumi=0, els_p=16. Expect:
  - ready_o=1 through 7 cycles, ready_o=0 after the 8th (occ=16, wrap bit set).
  - v1_o/v2_o=1 with data equal to the first two enqueued entries.
- Fill 6 entries, yumi_cnt=2 twice, deq_v once. Expect:
  - rptr=4, cptr=1.
  - Then roll_v_i: next cycle fe_queue1_o equals entry 1 and unissued=5.
- With 6 entries, rptr=4, cptr=2: assert clr_v_i, deq_v_i and enqueue of 2 entries together. Expect:
  - Next cycle cptr=rptr=wptr=3, v1_o=0, enqueue discarded.
- Wrap: cycle 40 entries through with 2 enqueues/cycle, yumi=2 and deq every cycle. Expect output order to match input order across index wrap, with no ready drop while occ<=14.
- With occ=15, v1=1 v2=0: expect ready_o=0, no write, wptr unchanged. After one deq, ready_o=1 the next cycle.
- Perf macro: hold fe_queue_v1_i high while full for 5 cycles. Expect stall_cnt_o=5 and hwm_o=16. Without the macro, both read 0.
